// File: rtl/mw_stage_sb.sv
// Memory/writeback stage: register-file and flag write decode plus an in-order
// posted store buffer that drains to the data-memory port over req/ack.
module mw_stage_sb #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       v,
    input  logic                       we,
    input  logic                       rmsel,
    input  logic [7:0]                 modrm,
    input  logic [1:0]                 opsize,
    input  logic [31:0]                aluval,
    input  logic [ADDR_W-1:0]          maddr,
    input  logic [31:0]                flag_ld,
    input  logic                       af,
    input  logic                       cf,
    input  logic                       of,
    output logic                       mw_stall,
    output logic                       v_rf_ld,
    output logic [2:0]                 drid,
    output logic [31:0]                rf_data,
    output logic [31:0]                v_flag_ld,
    output logic [31:0]                flags,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_data,
    output logic [1:0]                 mem_size,
    input  logic                       mem_ack,
    output logic                       sb_empty,
    output logic [$clog2(SB_DEPTH):0]  sb_count
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] addr_q [SB_DEPTH];
    logic [31:0]       data_q [SB_DEPTH];
    logic [1:0]        size_q [SB_DEPTH];

    logic mem_ind, st, full, enq, deq;

    function automatic logic [31:0] calc_flags(input logic [31:0] val,
                                               input logic [1:0]  sz,
                                               input logic        a_in,
                                               input logic        c_in,
                                               input logic        o_in);
        logic [31:0] f;
        logic        zf, sf;
        case (sz)
            2'b00: begin zf = (val[7:0] == 8'h00);    sf = val[7];  end
            2'b01: begin zf = (val[15:0] == 16'h0000); sf = val[15]; end
            default: begin zf = (val == 32'h0);        sf = val[31]; end
        endcase
        f     = 32'h0;
        f[0]  = c_in;
        f[2]  = ~^val[7:0];
        f[4]  = a_in;
        f[6]  = zf;
        f[7]  = sf;
        f[11] = o_in;
        return f;
    endfunction

    // Full is judged on the registered count only, so a same-cycle ack never frees a slot.
    always_comb begin
        mem_ind   = (modrm[7:6] != 2'b11);
        st        = v & we & rmsel & mem_ind;
        full      = (count_q == CNT_W'(SB_DEPTH));
        mw_stall  = st & full;
        enq       = st & ~full;
        mem_req   = (count_q != '0);
        deq       = mem_req & mem_ack;
        sb_empty  = ~mem_req;
        sb_count  = count_q;
        drid      = rmsel ? modrm[2:0] : modrm[5:3];
        v_rf_ld   = v & we & ~(rmsel & mem_ind);
        rf_data   = aluval;
        v_flag_ld = flag_ld & {32{v & ~mw_stall}};
        flags     = calc_flags(aluval, opsize, af, cf, of);
        mem_addr  = addr_q[rd_ptr_q];
        mem_data  = data_q[rd_ptr_q];
        mem_size  = size_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= maddr;
            data_q[wr_ptr_q] <= aluval;
            size_q[wr_ptr_q] <= opsize;
        end
    end

endmodule

// File: tb/tb_mw_stage_sb.sv
// Scoreboard bench for mw_stage_sb: directed scenarios followed by random traffic,
// with a queue-based model of the store buffer and arithmetic flag model.
module tb_mw_stage_sb;

    localparam int ADDR_W   = 32;
    localparam int SB_DEPTH = 4;

    logic              clk = 1'b0;
    logic              clr, v, we, rmsel, af, cf, of, mem_ack;
    logic [7:0]        modrm;
    logic [1:0]        opsize;
    logic [31:0]       aluval, flag_ld;
    logic [ADDR_W-1:0] maddr;
    logic              mw_stall, v_rf_ld, mem_req, sb_empty;
    logic [2:0]        drid;
    logic [31:0]       rf_data, v_flag_ld, flags, mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size;
    logic [2:0]        sb_count;

    mw_stage_sb #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .clr(clr), .v(v), .we(we), .rmsel(rmsel), .modrm(modrm),
        .opsize(opsize), .aluval(aluval), .maddr(maddr), .flag_ld(flag_ld),
        .af(af), .cf(cf), .of(of), .mw_stall(mw_stall), .v_rf_ld(v_rf_ld),
        .drid(drid), .rf_data(rf_data), .v_flag_ld(v_flag_ld), .flags(flags),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_size(mem_size), .mem_ack(mem_ack), .sb_empty(sb_empty),
        .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } entry_t;

    entry_t q[$];
    entry_t pend_e;
    logic   pend_push = 1'b0;
    logic   pend_rst  = 1'b0;
    logic   mon_en    = 1'b0;
    int     n_tests   = 0;
    int     n_fail    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_flags(input logic [31:0] val, input logic [1:0] sz,
                                              input logic a_in, input logic c_in, input logic o_in);
        int          width, ones;
        logic [31:0] f;
        width = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        ones  = 0;
        for (int i = 0; i < 8; i++) ones += int'(val[i]);
        f     = 32'h0;
        f[0]  = c_in;
        f[2]  = (ones % 2 == 0);
        f[4]  = a_in;
        f[6]  = ((val << (32 - width)) == 32'h0);
        f[7]  = val[width-1];
        f[11] = o_in;
        return f;
    endfunction

    // Apply the model consequences of the edge that just happened.
    task automatic commit();
        if (pend_rst) q.delete();
        else if (pend_push) q.push_back(pend_e);
        pend_rst  = 1'b0;
        pend_push = 1'b0;
    endtask

    task automatic drive(input logic iv, input logic iwe, input logic irm, input logic [7:0] im,
                         input logic [1:0] isz, input logic [31:0] ival, input logic [31:0] iaddr,
                         input logic iack);
        logic        mind, st, stall, rfld;
        logic [31:0] fl;
        @(posedge clk);
        commit();
        #1;
        clr = 1'b1; v = iv; we = iwe; rmsel = irm; modrm = im; opsize = isz;
        aluval = ival; maddr = iaddr; mem_ack = iack;
        flag_ld = $urandom; af = 1'($urandom); cf = 1'($urandom); of = 1'($urandom);
        #1;
        mind  = (im[7:6] != 2'b11);
        st    = iv && iwe && irm && mind;
        stall = st && (q.size() == SB_DEPTH);
        rfld  = iv && iwe && !(irm && mind);
        fl    = ref_flags(ival, isz, af, cf, of);
        chk("mw_stall", 64'(mw_stall), 64'(stall));
        chk("v_rf_ld", 64'(v_rf_ld), 64'(rfld));
        chk("drid", 64'(drid), 64'(irm ? im[2:0] : im[5:3]));
        chk("rf_data", 64'(rf_data), 64'(ival));
        chk("v_flag_ld", 64'(v_flag_ld), 64'((iv && !stall) ? flag_ld : 32'h0));
        chk("flags", 64'(flags), 64'(fl));
        if (st && !stall) begin
            pend_push = 1'b1;
            pend_e.a  = iaddr;
            pend_e.d  = ival;
            pend_e.s  = isz;
        end
    endtask

    task automatic idle(input logic iack);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 32'h0, 32'h0, iack);
    endtask

    task automatic store(input logic [31:0] ival, input logic [31:0] iaddr, input logic [1:0] isz,
                         input logic iack);
        drive(1'b1, 1'b1, 1'b1, 8'h03, isz, ival, iaddr, iack);
    endtask

    task automatic do_reset(input logic iack);
        @(posedge clk);
        commit();
        #1;
        clr = 1'b0; v = 1'b0; mem_ack = iack;
        pend_rst = 1'b1;
    endtask

    // Monitor: registered buffer state and head entry against the model queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_count", 64'(sb_count), 64'(q.size()));
            chk("mem_req", 64'(mem_req), 64'(q.size() != 0));
            chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
            if (q.size() != 0) begin
                chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
                chk("mem_data", 64'(mem_data), 64'(q[0].d));
                chk("mem_size", 64'(mem_size), 64'(q[0].s));
                if (clr && mem_ack) void'(q.pop_front());
            end
        end
    end

    initial begin
        clr = 1'b0; v = 1'b0; we = 1'b0; rmsel = 1'b0; modrm = 8'h0; opsize = 2'b0;
        aluval = 32'h0; maddr = 32'h0; flag_ld = 32'h0; af = 1'b0; cf = 1'b0; of = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Register destinations, both field selections
        drive(1'b1, 1'b1, 1'b1, 8'hC3, 2'b10, 32'h1234_5678, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h18, 2'b10, 32'h0000_00FF, 32'h0, 1'b0);

        // Single store held three cycles, then acknowledged
        store(32'hDEAD_BEEF, 32'h100, 2'b10, 1'b0);
        repeat (3) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill the buffer, stall with a same-cycle ack, then retry
        for (int i = 0; i < 4; i++) store(32'hA000_0000 + i, 32'h200 + 4 * i, 2'(i), 1'b0);
        store(32'hA000_0004, 32'h210, 2'b01, 1'b1);
        store(32'hA000_0004, 32'h210, 2'b01, 1'b0);
        repeat (6) idle(1'b1);

        // Enqueue and dequeue in the same cycle at count 2
        store(32'hB000_0001, 32'h300, 2'b10, 1'b0);
        store(32'hB000_0002, 32'h304, 2'b10, 1'b0);
        store(32'hB000_0003, 32'h308, 2'b10, 1'b1);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // Flag generation per operand size
        drive(1'b1, 1'b1, 1'b0, 8'hC0, 2'b00, 32'h0000_0100, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hC0, 2'b10, 32'h0000_0100, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hC0, 2'b01, 32'h0000_8000, 32'h0, 1'b0);

        // Reset with two entries queued and an ack in flight
        store(32'hC000_0001, 32'h400, 2'b10, 1'b0);
        store(32'hC000_0002, 32'h404, 2'b10, 1'b0);
        do_reset(1'b1);
        idle(1'b0);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0]  m;
            logic [31:0] val;
            m   = 8'($urandom);
            val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) << $urandom_range(0, 31)
                                              : $urandom;
            if ($urandom_range(0, 1) == 1) m[7:6] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom));
            end else begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                      m, 2'($urandom), val, $urandom, 1'($urandom_range(0, 2) == 0));
            end
        end

        repeat (SB_DEPTH + 4) idle(1'b1);
        @(posedge clk);
        commit();
        #1;
        chk("drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
